program_loader_memory: RTL and testbench

PROGRAM_LOADER_MEMORY -- requirements
Module: program_loader_memory

---
 rtl/program_loader_memory_pkg.sv | 30 +++
 rtl/sdp_ram.sv | 45 ++++
 rtl/program_loader_memory.sv | 166 ++++++++++++++++
 tb/tb_program_loader_memory.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_memory_pkg.sv
// Shared definitions for the program loader memory.
// Holds the loader FSM state encoding, default geometry and the derived
// constants MEM_SIZE and BYTES_PER_WORD. It also provides helpers so that
// parameterised instances can derive the same constants.
package program_loader_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_ADDR_LENGTH = 11;
  localparam int unsigned DEF_DATA_WIDTH  = 16;

  // Memory depth in words for a given word-address width.
  function automatic int unsigned mem_size(input int unsigned addr_length);
    return 32'd1 << addr_length;
  endfunction

  // Number of loader bytes that make up one instruction word.
  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 32'd8;
  endfunction

  localparam int unsigned MEM_SIZE       = mem_size(DEF_ADDR_LENGTH);
  localparam int unsigned BYTES_PER_WORD = bytes_per_word(DEF_DATA_WIDTH);

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
// Ports:
//   clk, reset            - clock; async active-high reset of the read register only
//   i_wr_en/addr/data     - write port
//   i_rd_en/addr, o_rd_data - read port; o_rd_data updates one edge after i_rd_en
//                           and holds its value while i_rd_en is low
// The storage array is never reset, so its contents survive a reset.
module sdp_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port with hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/program_loader_memory.sv
// Instruction memory with a byte-stream program loader and a fetch port.
// Ports:
//   clk, reset                 - clock, async active-high reset
//   load_start, load_len       - start a load of load_len words (idle/done only)
//   load_data, load_valid      - loader byte stream, little-endian per word
//   load_ready                 - a byte is accepted this cycle when valid&ready
//   load_busy, load_done       - load in progress / sticky completion flag
//   read_en, addr              - fetch request (ignored while busy)
//   instruction, instr_valid   - registered fetched word, one cycle latency
module program_loader_memory
  import program_loader_memory_pkg::*;
#(
  parameter int unsigned ADDR_LENGTH = DEF_ADDR_LENGTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_LENGTH:0]  load_len,
  input  logic [7:0]            load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done,
  input  logic                  read_en,
  input  logic [ADDR_LENGTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid
);

  localparam int unsigned MEM_DEPTH = mem_size(ADDR_LENGTH);
  localparam int unsigned BPW       = bytes_per_word(DATA_WIDTH);
  localparam int unsigned CNT_W     = ADDR_LENGTH + 1;
  localparam int unsigned IDX_W     = (BPW > 1) ? $clog2(BPW) : 1;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_waddr;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_load_ready;
  logic                  r_load_busy;
  logic                  r_load_done;
  logic                  r_instr_valid;
  logic                  w_ready_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_fetch;
  logic                  w_wr_en;
  logic [CNT_W-1:0]      w_len_clamped;

  assign w_start       = load_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_accept      = load_valid && r_load_ready;
  assign w_last_byte   = (r_idx == IDX_W'(BPW - 1));
  // Count-wide compare so a full-depth load ends at MEM_DEPTH instead of wrapping.
  assign w_last_word   = ((r_waddr + CNT_W'(1)) == r_count);
  assign w_len_clamped = (load_len > CNT_W'(MEM_DEPTH)) ? CNT_W'(MEM_DEPTH) : load_len;
  assign w_wr_en       = (r_state == ST_WRITE);
  assign w_fetch       = read_en && !r_load_busy;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start) begin
          w_state_nxt = (w_len_clamped == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        if (w_accept && w_last_byte) begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_state_nxt = w_last_word ? ST_DONE : ST_RECV;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the flags are registered with it.
  always_comb begin
    w_ready_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (w_state_nxt)
      ST_RECV:  begin w_ready_nxt = 1'b1; w_busy_nxt = 1'b1; end
      ST_WRITE: w_busy_nxt = 1'b1;
      ST_DONE:  w_done_nxt = 1'b1;
      default:  ;
    endcase
  end

  // Registered status outputs and fetch-valid flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_ready  <= 1'b0;
      r_load_busy   <= 1'b0;
      r_load_done   <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      r_load_ready  <= w_ready_nxt;
      r_load_busy   <= w_busy_nxt;
      r_load_done   <= w_done_nxt;
      r_instr_valid <= w_fetch;
    end
  end

  // Loader datapath: word count, write address and little-endian byte assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_waddr <= '0;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      if (w_start) begin
        r_count <= w_len_clamped;
        r_waddr <= '0;
        r_idx   <= '0;
      end
      if (w_accept) begin
        r_word[{r_idx, 3'b000} +: 8] <= load_data;
        r_idx <= w_last_byte ? '0 : r_idx + IDX_W'(1);
      end
      if (w_wr_en) begin
        r_waddr <= r_waddr + CNT_W'(1);
      end
    end
  end

  sdp_ram #(
    .AW (ADDR_LENGTH),
    .DW (DATA_WIDTH)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_waddr[ADDR_LENGTH-1:0]),
    .i_wr_data (r_word),
    .i_rd_en   (w_fetch),
    .i_rd_addr (addr),
    .o_rd_data (instruction)
  );

  assign load_ready  = r_load_ready;
  assign load_busy   = r_load_busy;
  assign load_done   = r_load_done;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_program_loader_memory.sv
// Self-checking bench for program_loader_memory (ADDR_LENGTH=11, DATA_WIDTH=16).
module tb_program_loader_memory;

  localparam int unsigned AL  = 11;
  localparam int unsigned DW  = 16;
  localparam int unsigned MEM = 2048;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic [AL:0]   load_len;
  logic [7:0]    load_data;
  logic          load_valid;
  logic          load_ready;
  logic          load_busy;
  logic          load_done;
  logic          read_en;
  logic [AL-1:0] addr;
  logic [DW-1:0] instruction;
  logic          instr_valid;

  always #5 clk = ~clk;

  program_loader_memory #(.ADDR_LENGTH(AL), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .load_len    (load_len),
    .load_data   (load_data),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .read_en     (read_en),
    .addr        (addr),
    .instruction (instruction),
    .instr_valid (instr_valid)
  );

  logic [DW-1:0] mdl [MEM];
  logic [DW-1:0] sb [$];
  logic [DW-1:0] wq [$];
  logic [DW-1:0] exp_w;
  logic [DW-1:0] prev_instr;
  int n_checks = 0;
  int n_fail   = 0;
  bit stalled  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every instr_valid pops one expected word.
  always @(negedge clk) begin
    if (!reset && instr_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_w = sb.pop_front();
        check_eq("fetch_data", 32'(instruction), 32'(exp_w));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (stalled) return;
    load_data  = b;
    load_valid = 1'b1;
    n = 0;
    while (load_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      check_eq("ready_timeout", 32'(load_ready), 32'd1);
      stalled    = 1'b1;
      load_valid = 1'b0;
      return;
    end
    tick();
    if (gap) begin
      load_valid = 1'b0;
      load_data  = 8'hEE;
      tick();
    end
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_eq("load_done", 32'(load_done), 32'd1);
  endtask

  task automatic start_load(input logic [AL:0] len);
    stalled    = 1'b0;
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  // Loads the words held in wq; model updated once each word is fully sent.
  task automatic load_words(input logic [AL:0] len, input bit gap);
    int nw;
    logic [DW-1:0] w;
    nw = (int'(len) > int'(MEM)) ? int'(MEM) : int'(len);
    start_load(len);
    for (int i = 0; i < nw; i++) begin
      w = wq[i];
      send_byte(w[7:0], gap);
      send_byte(w[15:8], gap);
      if (!stalled) mdl[i] = w;
    end
    load_valid = 1'b0;
    wait_done();
    check_eq("busy_after_load", 32'(load_busy), 32'd0);
    check_eq("ready_after_load", 32'(load_ready), 32'd0);
  endtask

  // Back-to-back fetches of n words starting at a.
  task automatic fetch(input int a, input int n);
    for (int i = 0; i < n; i++) begin
      read_en = 1'b1;
      addr    = AL'(a + i);
      sb.push_back(mdl[a + i]);
      tick();
    end
    read_en = 1'b0;
    tick();
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    load_len   = '0;
    load_data  = '0;
    load_valid = 1'b0;
    read_en    = 1'b0;
    addr       = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state with no stimulus.
    check_eq("rst_instruction", 32'(instruction), 32'd0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_load_ready", 32'(load_ready), 32'd0);
    check_eq("rst_load_done", 32'(load_done), 32'd0);
    check_eq("rst_load_busy", 32'(load_busy), 32'd0);

    // Reference stream 34 12 78 56 BC 9A, valid held high.
    wq = '{16'h1234, 16'h5678, 16'h9ABC};
    load_words(12'd3, 1'b0);
    fetch(1, 1);
    fetch(0, 3);

    // Overwrite, then reload the reference stream with valid toggling.
    wq = '{16'h1111, 16'h2222, 16'h3333};
    load_words(12'd3, 1'b0);
    fetch(0, 3);
    wq = '{16'h1234, 16'h5678, 16'h9ABC};
    load_words(12'd3, 1'b1);
    fetch(0, 3);

    // Fetch requested throughout a load: no valid, instruction held.
    prev_instr = instruction;
    wq = '{16'hA1A1, 16'hB2B2};
    start_load(12'd2);
    read_en = 1'b1;
    addr    = AL'(2);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA1, 1'b0);
    check_eq("hold_instr_mid", 32'(instruction), 32'(prev_instr));
    check_eq("hold_valid_mid", 32'(instr_valid), 32'd0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hB2, 1'b0);
    read_en    = 1'b0;
    load_valid = 1'b0;
    mdl[0] = 16'hA1A1;
    mdl[1] = 16'hB2B2;
    wait_done();
    check_eq("hold_instr_end", 32'(instruction), 32'(prev_instr));
    fetch(0, 3);

    // Zero-length load from IDLE goes straight to DONE.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst2_instruction", 32'(instruction), 32'd0);
    check_eq("rst2_load_done", 32'(load_done), 32'd0);
    start_load(12'd0);
    check_eq("len0_done", 32'(load_done), 32'd1);
    check_eq("len0_busy", 32'(load_busy), 32'd0);
    check_eq("len0_ready", 32'(load_ready), 32'd0);
    fetch(0, 3);

    // Oversized length is clamped to the full memory depth.
    wq.delete();
    for (int i = 0; i < int'(MEM); i++) wq.push_back(DW'((i * 40503) + 1));
    load_words(12'(MEM + 5), 1'b0);
    fetch(0, 2);
    fetch(1023, 1);
    fetch(int'(MEM) - 2, 2);

    // Reset after one and a half words: word 0 survives.
    start_load(12'd2);
    send_byte(8'h44, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    load_valid = 1'b0;
    mdl[0] = 16'h4444;
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(load_busy), 32'd0);
    check_eq("midrst_ready", 32'(load_ready), 32'd0);
    check_eq("midrst_done", 32'(load_done), 32'd0);
    check_eq("midrst_instruction", 32'(instruction), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("post_rst_done", 32'(load_done), 32'd0);
    fetch(0, 2);
    wq = '{16'h6666, 16'h7777};
    load_words(12'd2, 1'b0);
    fetch(0, 3);

    tick();
    check_eq("sb_final", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
